hazard_unit_mc: RTL and testbench

Parametrised pipeline hazard unit for the 5-stage MIPS core, sitting between the IF/ID and ID/EX pipeline registers. It does three things:
- Detects load-use hazards and holds the pipeline for a configurable number of bubble cycles, with `$0` and unused source operands excluded.
- Tracks an optional multi-cycle multiply/divide unit and stalls dependent instructions until it finishes.
- Flushes wrong-path instructions on a taken branch and keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/hazard_unit_mc.sv | 143 ++++++++++++++
 tb/tb_hazard_unit_mc.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: load-use bubbles, optional mul/div dependency stall, branch flush and
// a saturating stall-cycle counter. Define HAZARD_MULDIV_EN to build the mul/div tracker.
module hazard_unit_mc #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             IF_ID_uses_rs,
  input  logic             IF_ID_uses_rt,
  input  logic             IF_ID_md_dep,
  input  logic [REG_W-1:0] ID_EX_dest,
  input  logic             ID_EX_mem_read,
  input  logic             md_start,
  input  logic             branch_taken,
  output logic             pc_load,
  output logic             IF_ID_load,
  output logic             control_mux_sel,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {StRun, StLdStall} state_e;

  localparam logic [3:0] LdInit = 4'(LOAD_STALL - 1);

  state_e           state_q, state_d;
  logic [3:0]       ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;
  logic             md_stall;
  logic             stall;

  // $0 is never a real producer, so a load targeting it cannot create a hazard.
  always_comb begin
    lu = ID_EX_mem_read && (ID_EX_dest != '0) &&
         ((IF_ID_uses_rs && (IF_ID_rs == ID_EX_dest)) ||
          (IF_ID_uses_rt && (IF_ID_rt == ID_EX_dest)));
  end

`ifdef HAZARD_MULDIV_EN
  logic [5:0] md_cnt_q, md_cnt_d;

  // A new issue restarts the countdown; the unit does not queue operations.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = 6'(MD_LATENCY);
    end else if (md_cnt_q != 6'd0) begin
      md_cnt_d = md_cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q <= 6'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    md_busy  = (md_cnt_q != 6'd0);
    md_stall = md_busy && IF_ID_md_dep;
  end
`else
  logic unused_md;

  always_comb begin
    unused_md = md_start ^ IF_ID_md_dep;
    md_busy   = 1'b0;
    md_stall  = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    if (branch_taken) begin
      state_d  = StRun;
      ld_cnt_d = 4'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu && (LOAD_STALL > 1)) begin
            state_d  = StLdStall;
            ld_cnt_d = LdInit;
          end
        end
        StLdStall: begin
          ld_cnt_d = ld_cnt_q - 4'd1;
          if (ld_cnt_q == 4'd1) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall = ((state_q == StRun) && lu) || (state_q == StLdStall) || md_stall;

    pc_load         = ~stall;
    IF_ID_load      = ~stall;
    control_mux_sel = ~stall;
    IF_ID_flush     = 1'b0;
    ID_EX_flush     = 1'b0;
    // A taken branch squashes the younger instructions, so any pending stall is moot.
    if (branch_taken) begin
      pc_load         = 1'b1;
      IF_ID_load      = 1'b1;
      control_mux_sel = 1'b0;
      IF_ID_flush     = 1'b1;
      ID_EX_flush     = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && !branch_taken && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    stall_cnt = stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      ld_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench: two instances (LOAD_STALL=1/CNT_W=2 and LOAD_STALL=3) on shared stimulus.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, dest;
  logic       uses_rs, uses_rt, md_dep, mem_read, md_start, branch_taken;

  logic       pc1, ifl1, cms1, iff1, idf1, busy1;
  logic [1:0] cnt1;
  logic       pc3, ifl3, cms3, iff3, idf3, busy3;
  logic [15:0] cnt3;

  int tests = 0;
  int fails = 0;

  localparam logic [4:0] CtlRun    = 5'b11100;
  localparam logic [4:0] CtlStall  = 5'b00000;
  localparam logic [4:0] CtlBranch = 5'b11011;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_W(5), .LOAD_STALL(1), .MD_LATENCY(4), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .IF_ID_rs(rs), .IF_ID_rt(rt), .IF_ID_uses_rs(uses_rs),
    .IF_ID_uses_rt(uses_rt), .IF_ID_md_dep(md_dep), .ID_EX_dest(dest),
    .ID_EX_mem_read(mem_read), .md_start(md_start), .branch_taken(branch_taken),
    .pc_load(pc1), .IF_ID_load(ifl1), .control_mux_sel(cms1), .IF_ID_flush(iff1),
    .ID_EX_flush(idf1), .md_busy(busy1), .stall_cnt(cnt1)
  );

  hazard_unit_mc #(.REG_W(5), .LOAD_STALL(3), .MD_LATENCY(4), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .IF_ID_rs(rs), .IF_ID_rt(rt), .IF_ID_uses_rs(uses_rs),
    .IF_ID_uses_rt(uses_rt), .IF_ID_md_dep(md_dep), .ID_EX_dest(dest),
    .ID_EX_mem_read(mem_read), .md_start(md_start), .branch_taken(branch_taken),
    .pc_load(pc3), .IF_ID_load(ifl3), .control_mux_sel(cms3), .IF_ID_flush(iff3),
    .ID_EX_flush(idf3), .md_busy(busy3), .stall_cnt(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp1, input logic [4:0] exp3);
    chk({tag, "_ctl1"}, {27'd0, pc1, ifl1, cms1, iff1, idf1}, {27'd0, exp1});
    chk({tag, "_ctl3"}, {27'd0, pc3, ifl3, cms3, iff3, idf3}, {27'd0, exp3});
  endtask

  task automatic chk_cnt(input string tag, input int exp1, input int exp3);
    chk({tag, "_cnt1"}, {30'd0, cnt1}, exp1);
    chk({tag, "_cnt3"}, {16'd0, cnt3}, exp3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs = 5'd0; rt = 5'd0; dest = 5'd0; uses_rs = 1'b0; uses_rt = 1'b0; md_dep = 1'b0;
    mem_read = 1'b0; md_start = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_lu();
    mem_read = 1'b1; dest = 5'd8; rs = 5'd8; uses_rs = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    chk_ctl("reset", CtlRun, CtlRun);
    chk_cnt("reset", 0, 0);
    chk("reset_busy", {30'd0, busy1, busy3}, 32'd0);

    // Load-use on rs: one bubble for dut1, three for dut3.
    set_lu();
    #1 chk_ctl("lu_c1", CtlStall, CtlStall);
    tick();
    idle();
    #1 chk_ctl("lu_c2", CtlRun, CtlStall);
    chk_cnt("lu_c2", 1, 1);
    tick();
    chk_ctl("lu_c3", CtlRun, CtlStall);
    tick();
    chk_ctl("lu_c4", CtlRun, CtlRun);
    chk_cnt("lu_c4", 1, 3);

    // No false hazards: $0 destination, and rt match with uses_rt clear.
    mem_read = 1'b1; dest = 5'd0; rs = 5'd0; uses_rs = 1'b1;
    #1 chk_ctl("dest0", CtlRun, CtlRun);
    uses_rs = 1'b0; dest = 5'd9; rt = 5'd9; uses_rt = 1'b0;
    #1 chk_ctl("rt_unused", CtlRun, CtlRun);
    uses_rt = 1'b1;
    #1 chk_ctl("rt_used", CtlStall, CtlStall);
    idle();
    tick();
    chk_cnt("nofalse", 1, 3);

    // Taken branch on the second stall cycle of dut3.
    do_reset();
    set_lu();
    tick();
    idle();
    branch_taken = 1'b1;
    #1 chk_ctl("br_c2", CtlBranch, CtlBranch);
    tick();
    branch_taken = 1'b0;
    #1 chk_ctl("br_c3", CtlRun, CtlRun);
    chk_cnt("br_c3", 1, 1);

    // Hold the hazard four cycles: dut1 saturates at 3, dut3 re-enters LD_STALL.
    set_lu();
    for (int i = 0; i < 4; i++) tick();
    idle();
    #1 chk_ctl("sat", CtlRun, CtlStall);
    chk_cnt("sat", 3, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk_ctl("rst_mid", CtlRun, CtlRun);
    chk_cnt("rst_mid", 0, 0);
    chk("rst_mid_busy", {30'd0, busy1, busy3}, 32'd0);

    // Mul/div dependency.
    md_start = 1'b1;
    #1 chk_ctl("md_issue", CtlRun, CtlRun);
    chk("md_issue_busy", {30'd0, busy1, busy3}, 32'd0);
    tick();
    md_start = 1'b0;
    md_dep = 1'b1;
`ifdef HAZARD_MULDIV_EN
    for (int i = 0; i < 4; i++) begin
      #1 chk_ctl("md_busy_ctl", CtlStall, CtlStall);
      chk("md_busy", {30'd0, busy1, busy3}, 32'd3);
      tick();
    end
    chk_ctl("md_done", CtlRun, CtlRun);
    chk("md_done_busy", {30'd0, busy1, busy3}, 32'd0);
    chk_cnt("md_done", 3, 4);
`else
    for (int i = 0; i < 5; i++) begin
      #1 chk_ctl("md_off_ctl", CtlRun, CtlRun);
      chk("md_off_busy", {30'd0, busy1, busy3}, 32'd0);
      tick();
    end
    chk_cnt("md_off", 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
